pipe_fetch: RTL and testbench

- Pipelined fetch stage of the Y86-64 core: holds the PC, decodes the instruction at that PC, predicts the next PC and loads the fetch/decode (D) pipeline register.
- Sits directly upstream of decode; every `D_*` output is consumed unchanged by decode.
- Applies stall, bubble and redirect requests from the pipeline control logic.
- Runs a two-state halt FSM so nothing is fetched past a faulting or halting instruction.

---
 rtl/pipe_fetch.sv | 199 +++++++++++++++++++
 tb/tb_pipe_fetch.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch.sv
// Y86-64 fetch stage: PC register, instruction split/align, next-PC prediction, D pipeline register and halt FSM.
// Optional macro PIPE_FETCH_BTFNT_EN: conditional jXX predicted backward-taken / forward-not-taken.
module pipe_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_bytes,
  input  logic        f_stall,
  input  logic        d_bubble,
  input  logic        m_mispredict,
  input  logic [63:0] m_valA,
  input  logic        w_ret,
  input  logic [63:0] w_valM,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic        halted
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned EXT_W  = WORD_W + 1;
  localparam int unsigned STAT_W = 3;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned LEN_W  = 4;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam logic [NIB_W-1:0] I_HALT   = 4'h0;
  localparam logic [NIB_W-1:0] I_NOP    = 4'h1;
  localparam logic [NIB_W-1:0] I_JXX    = 4'h7;
  localparam logic [NIB_W-1:0] I_CALL   = 4'h8;
  localparam logic [NIB_W-1:0] I_MAX    = 4'hB;
  localparam logic [NIB_W-1:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [STAT_W-1:0] stat;
    logic [NIB_W-1:0]  icode;
    logic [NIB_W-1:0]  ifun;
    logic [NIB_W-1:0]  rA;
    logic [NIB_W-1:0]  rB;
    logic [WORD_W-1:0] valC;
    logic [WORD_W-1:0] valP;
  } dreg_t;

  localparam dreg_t BUBBLE = '{
    stat: STAT_AOK, icode: I_NOP, ifun: 4'h0, rA: REG_NONE, rB: REG_NONE,
    valC: 64'd0, valP: 64'd0
  };

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pcNext;
  dreg_t             dReg;

  logic [NIB_W-1:0]  rawIcode;
  logic [NIB_W-1:0]  rawIfun;
  logic              needRegids;
  logic              needValC;
  logic [LEN_W-1:0]  instrLen;
  logic [EXT_W-1:0]  lastByte;
  logic              addrErr;
  dreg_t             fetched;
  logic [WORD_W-1:0] predPc;
  logic              dLoad;
  logic              dBubble;

  // Split and align the instruction bytes presented at the current PC.
  always_comb begin : split_align
    rawIcode   = imem_bytes[7:4];
    rawIfun    = imem_bytes[3:0];
    needRegids = 1'b0;
    needValC   = 1'b0;
    case (rawIcode)
      4'h2, 4'h6, 4'hA, 4'hB: needRegids = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        needRegids = 1'b1;
        needValC   = 1'b1;
      end
      4'h7, 4'h8: needValC = 1'b1;
      default: ;
    endcase

    fetched.rA   = needRegids ? imem_bytes[15:12] : REG_NONE;
    fetched.rB   = needRegids ? imem_bytes[11:8]  : REG_NONE;
    fetched.valC = '0;
    if (needValC) begin
      fetched.valC = needRegids ? imem_bytes[79:16] : imem_bytes[71:8];
    end

    instrLen     = LEN_W'(1) + LEN_W'(needRegids) + (needValC ? LEN_W'(8) : LEN_W'(0));
    fetched.valP = pc + WORD_W'(instrLen);

    // One extra bit catches a wrap past 2^64 as well as the memory bound.
    lastByte = {1'b0, pc} + EXT_W'(instrLen) - EXT_W'(1);
    addrErr  = (lastByte >= EXT_W'(IMEM_BYTES));

    fetched.icode = addrErr ? I_NOP : rawIcode;
    fetched.ifun  = addrErr ? 4'h0  : rawIfun;
    if (addrErr) begin
      fetched.stat = STAT_ADR;
    end else if (rawIcode > I_MAX) begin
      fetched.stat = STAT_INS;
    end else if (rawIcode == I_HALT) begin
      fetched.stat = STAT_HLT;
    end else begin
      fetched.stat = STAT_AOK;
    end
  end

  // Next-PC prediction for the sequential path.
  always_comb begin : predict
    predPc = fetched.valP;
    if (fetched.icode == I_JXX || fetched.icode == I_CALL) begin
      predPc = fetched.valC;
    end
`ifdef PIPE_FETCH_BTFNT_EN
    if (fetched.icode == I_JXX && fetched.ifun != 4'h0 && fetched.valC >= pc) begin
      predPc = fetched.valP;
    end
`endif
  end

  // PC select, D-register control and halt FSM transitions.
  always_comb begin : next_state
    stateNext = state;
    pcNext    = pc;
    dLoad     = 1'b0;
    dBubble   = 1'b0;

    if (m_mispredict) begin
      pcNext = m_valA;
    end else if (w_ret) begin
      pcNext = w_valM;
    end else if (!f_stall && state != HALTED) begin
      pcNext = predPc;
    end

    if (d_bubble) begin
      dBubble = 1'b1;
    end else if (!f_stall) begin
      if (state == HALTED) dBubble = 1'b1;
      else                 dLoad   = 1'b1;
    end

    case (state)
      RUN: begin
        if (dLoad && !m_mispredict && !w_ret && fetched.stat != STAT_AOK) begin
          stateNext = HALTED;
        end
      end
      HALTED: begin
        if (m_mispredict || w_ret) stateNext = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      dReg  <= BUBBLE;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (dBubble) begin
        dReg <= BUBBLE;
      end else if (dLoad) begin
        dReg <= fetched;
      end
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == HALTED);
  assign D_stat    = dReg.stat;
  assign D_icode   = dReg.icode;
  assign D_ifun    = dReg.ifun;
  assign D_rA      = dReg.rA;
  assign D_rB      = dReg.rB;
  assign D_valC    = dReg.valC;
  assign D_valP    = dReg.valP;

endmodule

// File: tb/tb_pipe_fetch.sv
// Scoreboard bench for pipe_fetch: directed fetch scenarios, then randomized control traffic over a random program.
module tb_pipe_fetch;

  localparam int unsigned IMEM_BYTES = 1024;
  localparam logic [63:0] RESET_PC   = 64'h0;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } dreg_t;

  typedef struct packed {
    logic [63:0] pc;
    logic        halted;
    dreg_t       d;
  } exp_t;

  localparam dreg_t BUBBLE = '{3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0};

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [79:0] imem_bytes;
  logic        f_stall, d_bubble, m_mispredict, w_ret;
  logic [63:0] m_valA, w_valM;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        halted;

  logic [7:0]  mem [IMEM_BYTES];
  bit   [15:0] hasReg   = 16'h0C7C;
  bit   [15:0] hasConst = 16'h01B8;

  exp_t        q[$];
  logic [63:0] mPc;
  logic        mHalted;
  dreg_t       mD;
  int          nAssert = 0;
  int          nFail   = 0;

  pipe_fetch #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_bytes(imem_bytes),
    .f_stall(f_stall), .d_bubble(d_bubble), .m_mispredict(m_mispredict), .m_valA(m_valA),
    .w_ret(w_ret), .w_valM(w_valM), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .halted(halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: bytes past the end read as zero.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      if ({1'b0, imem_addr} + 65'(i) < 65'(IMEM_BYTES))
        imem_bytes[8*i +: 8] = mem[imem_addr[9:0] + 10'(i)];
      else
        imem_bytes[8*i +: 8] = 8'h00;
    end
  end

  function automatic logic [7:0] memAt(input logic [64:0] a);
    if (a < 65'(IMEM_BYTES)) return mem[a[9:0]];
    return 8'h00;
  endfunction

  // Reference: what the instruction at pc should look like in D, and where fetch goes next.
  function automatic void modelFetch(input logic [63:0] pc, output dreg_t d, output logic [63:0] pred);
    logic [7:0]  b [10];
    int unsigned len, off;
    bit          r, c;
    for (int i = 0; i < 10; i++) b[i] = memAt({1'b0, pc} + 65'(i));
    d.icode = b[0][7:4];
    d.ifun  = b[0][3:0];
    r = hasReg[d.icode];
    c = hasConst[d.icode];
    d.rA = r ? b[1][7:4] : 4'hF;
    d.rB = r ? b[1][3:0] : 4'hF;
    off = r ? 2 : 1;
    d.valC = 64'd0;
    if (c) for (int j = 0; j < 8; j++) d.valC[8*j +: 8] = b[j + off];
    len = 1 + (r ? 1 : 0) + (c ? 8 : 0);
    d.valP = pc + 64'(len);
    if (pc > 64'(IMEM_BYTES - len)) begin
      d.stat = 3'd3; d.icode = 4'h1; d.ifun = 4'h0;
    end else if (d.icode > 4'hB) d.stat = 3'd4;
    else if (d.icode == 4'h0)    d.stat = 3'd2;
    else                         d.stat = 3'd1;
    pred = d.valP;
    if (d.icode == 4'h7 || d.icode == 4'h8) pred = d.valC;
`ifdef PIPE_FETCH_BTFNT_EN
    if (d.icode == 4'h7 && d.ifun != 4'h0 && d.valC >= pc) pred = d.valP;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of control inputs (called at a falling edge), advance the model, queue the expectation.
  task automatic step(input bit r, input bit mis, input logic [63:0] va, input bit ret,
                      input logic [63:0] vm, input bit st, input bit bub);
    dreg_t       f;
    logic [63:0] pred, nPc;
    logic        nHalt;
    dreg_t       nD;
    exp_t        e;
    rst = r; m_mispredict = mis; m_valA = va; w_ret = ret; w_valM = vm; f_stall = st; d_bubble = bub;
    modelFetch(mPc, f, pred);
    if (r)                    nPc = RESET_PC;
    else if (mis)             nPc = va;
    else if (ret)             nPc = vm;
    else if (st || mHalted)   nPc = mPc;
    else                      nPc = pred;
    if (r || bub)             nD = BUBBLE;
    else if (st)              nD = mD;
    else if (mHalted)         nD = BUBBLE;
    else                      nD = f;
    if (r)                    nHalt = 1'b0;
    else if (mHalted)         nHalt = !(mis || ret);
    else                      nHalt = !st && !bub && !mis && !ret && (f.stat != 3'd1);
    mPc = nPc; mD = nD; mHalted = nHalt;
    e.pc = nPc; e.halted = nHalt; e.d = nD;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 64'd0, 0, 64'd0, 0, 0);
  endtask

  task automatic doReset();
    step(1, 0, 64'd0, 0, 64'd0, 0, 0);
    step(1, 0, 64'd0, 0, 64'd0, 0, 0);
  endtask

  task automatic fillMem(input logic [7:0] v);
    for (int i = 0; i < IMEM_BYTES; i++) mem[i] = v;
  endtask

  function automatic logic [63:0] randTarget();
    int unsigned k = $urandom_range(0, 19);
    if (k == 0) return {32'($urandom), 32'($urandom)};
    if (k == 1) return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
    return 64'($urandom_range(0, IMEM_BYTES + 12));
  endfunction

  // Random but well-formed instruction stream, jump/call targets mostly in range.
  task automatic buildProgram();
    int unsigned a = 0;
    for (int i = 0; i < IMEM_BYTES; i++) mem[i] = 8'($urandom);
    while (a + 10 <= IMEM_BYTES) begin
      logic [3:0]  ic;
      logic [63:0] c;
      int unsigned k;
      k  = $urandom_range(0, 99);
      ic = (k < 3) ? 4'h0 : (k < 6) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(1, 11));
      mem[a] = {ic, 4'($urandom_range(0, 6))};
      a++;
      if (hasReg[ic]) begin
        mem[a] = 8'($urandom);
        a++;
      end
      if (hasConst[ic]) begin
        c = (ic == 4'h7 || ic == 4'h8) ? 64'($urandom_range(0, IMEM_BYTES + 8)) : {32'($urandom), 32'($urandom)};
        for (int j = 0; j < 8; j++) mem[a + j] = c[8*j +: 8];
        a += 8;
      end
    end
  endtask

  // Monitor: every cycle after the rising edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t  e;
    dreg_t act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        act = '{D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP};
        chk("imem_addr", imem_addr, e.pc);
        chk("halted", 64'(halted), 64'(e.halted));
        nAssert++;
        if (act !== e.d) begin
          nFail++;
          $display("FAIL D_reg: got %h expected %h (stat,icode,ifun,rA,rB,valC,valP)", act, e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; f_stall = 0; d_bubble = 0; m_mispredict = 0; w_ret = 0; m_valA = 0; w_valM = 0;
    mPc = RESET_PC; mHalted = 0; mD = BUBBLE;
    fillMem(8'h00);
    @(negedge clk);

    // irmovq $0x100,%rax at 0
    mem[0] = 8'h30; mem[1] = 8'hF0; mem[2] = 8'h00; mem[3] = 8'h01;
    doReset();
    chk("rst_pc", imem_addr, 64'd0);
    chk("rst_stat", 64'(D_stat), 64'd1);
    idle();
    chk("irmov_icode", 64'(D_icode), 64'd3);
    chk("irmov_rA", 64'(D_rA), 64'hF);
    chk("irmov_rB", 64'(D_rB), 64'd0);
    chk("irmov_valC", D_valC, 64'h100);
    chk("irmov_valP", D_valP, 64'd10);
    chk("irmov_pc", imem_addr, 64'd10);

    // halt at 8, then a redirect out of HALTED
    fillMem(8'h10);
    mem[8] = 8'h00;
    doReset();
    repeat (9) idle();
    chk("halt_stat", 64'(D_stat), 64'd2);
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_pc", imem_addr, 64'd9);
    repeat (2) idle();
    chk("halt_hold_pc", imem_addr, 64'd9);
    chk("halt_bubble", 64'(D_icode), 64'd1);
    step(0, 1, 64'h30, 0, 64'd0, 0, 0);
    chk("halt_exit_pc", imem_addr, 64'h30);
    chk("halt_exit_flag", 64'(halted), 64'd0);

    // invalid icode
    mem[8] = 8'h10; mem[0] = 8'hC0;
    doReset();
    idle();
    chk("ins_stat", 64'(D_stat), 64'd4);
    chk("ins_halted", 64'(halted), 64'd1);

    // rrmovq straddling the end of memory
    mem[0] = 8'h10; mem[IMEM_BYTES-1] = 8'h20;
    doReset();
    step(0, 0, 64'd0, 1, 64'(IMEM_BYTES - 1), 0, 0);
    idle();
    chk("adr_stat", 64'(D_stat), 64'd3);
    chk("adr_icode", 64'(D_icode), 64'd1);

    // jne forward to 0x40, then mispredict back to fall-through
    mem[IMEM_BYTES-1] = 8'h10;
    mem[32'h20] = 8'h74; mem[32'h21] = 8'h40;
    for (int j = 1; j < 8; j++) mem[32'h21 + j] = 8'h00;
    doReset();
    step(0, 0, 64'd0, 1, 64'h20, 0, 0);
    idle();
`ifdef PIPE_FETCH_BTFNT_EN
    chk("jne_pred_pc", imem_addr, 64'h29);
`else
    chk("jne_pred_pc", imem_addr, 64'h40);
`endif
    chk("jne_valC", D_valC, 64'h40);
    step(0, 1, 64'h29, 0, 64'd0, 0, 1);
    chk("mispred_pc", imem_addr, 64'h29);
    chk("mispred_bubble", D_valP, 64'd0);

    // stall, stall+bubble, ret redirect
    doReset();
    idle(); idle();
    step(0, 0, 64'd0, 0, 64'd0, 1, 0);
    step(0, 0, 64'd0, 0, 64'd0, 1, 0);
    chk("stall_pc", imem_addr, 64'd2);
    chk("stall_valP", D_valP, 64'd2);
    step(0, 0, 64'd0, 0, 64'd0, 1, 1);
    chk("stallbub_pc", imem_addr, 64'd2);
    chk("stallbub_icode", 64'(D_icode), 64'd1);
    step(0, 0, 64'd0, 1, 64'h80, 0, 0);
    chk("ret_pc", imem_addr, 64'h80);

    // randomized control over a random program
    buildProgram();
    doReset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, randTarget(),
           $urandom_range(0, 9) == 0, randTarget(),
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
